// File: rtl/i2s_rx_deserializer_pkg.sv
// i2s_rx_deserializer_pkg: shared state encodings and defaults for the I2S receive path
package i2s_rx_deserializer_pkg;
  localparam int DEF_DATA_WIDTH = 24;
  localparam logic LR_LEFT = 1'b0;
  typedef enum logic [1:0] {WAIT_SYNC, SHIFT, FULL} i2s_state_t;
endpackage

// File: rtl/i2s_rx_deserializer_sync.sv
// i2s_input_sync: multi-flop synchronizer for one async input with rising-edge detect
module i2s_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_chain;
  logic r_prev;
  // shift the async input through the chain and keep last synced value for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
      r_prev <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      r_prev <= r_chain[SYNC_STAGES-1];
    end
  end
  assign o_q = r_chain[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
endmodule

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer: oversampling I2S receiver recovering stereo PCM words in the clk_100 domain
module i2s_rx_deserializer
  import i2s_rx_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_100,
  input  logic                  reset,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lr,
  input  logic                  i2s_sdata,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  output logic                  frame_err
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  logic w_bclk_rise, w_lr_s, w_sd_s, w_boundary;
  logic [2:0] w_unused;
  i2s_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_shift, r_left_hold;
  logic r_left_ok, r_lr_prev;

  i2s_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(clk_100), .reset(reset), .i_d(i2s_bclk), .o_q(w_unused[0]), .o_rise(w_bclk_rise)
  );
  i2s_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lr (
    .clk(clk_100), .reset(reset), .i_d(i2s_lr), .o_q(w_lr_s), .o_rise(w_unused[1])
  );
  i2s_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
    .clk(clk_100), .reset(reset), .i_d(i2s_sdata), .o_q(w_sd_s), .o_rise(w_unused[2])
  );

  assign w_boundary = w_lr_s != r_lr_prev;

  // channel FSM: acts on bclk rising edges only; the boundary slot is the old channel's delay bit
  always_ff @(posedge clk_100) begin
    if (reset) begin
      r_state <= WAIT_SYNC;
      r_cnt <= '0;
      r_shift <= '0;
      r_left_hold <= '0;
      r_left_ok <= 1'b0;
      r_lr_prev <= 1'b0;
      left_sample <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err <= 1'b0;
      if (w_bclk_rise) begin
        r_lr_prev <= w_lr_s;
        if (w_boundary) r_cnt <= '0;
        case (r_state)
          WAIT_SYNC: begin
            if (w_boundary && w_lr_s == LR_LEFT) begin
              r_state <= SHIFT;
              r_left_ok <= 1'b0;
            end
          end
          SHIFT: begin
            if (w_boundary) begin
              frame_err <= 1'b0 | 1'b1;
              r_left_ok <= 1'b0;
            end else begin
              r_shift <= {r_shift[DATA_WIDTH-2:0], w_sd_s};
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == CW'(DATA_WIDTH - 1)) r_state <= FULL;
            end
          end
          FULL: begin
            if (w_boundary) begin
              r_state <= SHIFT;
              if (w_lr_s != LR_LEFT) begin
                r_left_hold <= r_shift;
                r_left_ok <= 1'b1;
              end else begin
                r_left_ok <= 1'b0;
                if (r_left_ok) begin
                  left_sample <= r_left_hold;
                  right_sample <= r_shift;
                  sample_valid <= 1'b1;
                end
              end
            end
          end
          default: r_state <= WAIT_SYNC;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb_i2s_rx_deserializer: scoreboard bench driving I2S frames and checking recovered stereo words
module tb_i2s_rx_deserializer;
  localparam int DW = 24;
  localparam int HB = 4;
  localparam int FRAME = 64 * 2 * HB;
  logic clk = 1'b0, rst = 1'b1, bclk = 1'b0, lr = 1'b0, sd = 1'b0;
  logic [DW-1:0] left_s, right_s;
  logic valid, ferr;
  int checks = 0, errors = 0, n_valid = 0, n_err = 0, cyc = 0, last_v = 0;
  bit space_en = 1'b0;
  logic [2*DW-1:0] q[$];

  always #5 clk = ~clk;

  i2s_rx_deserializer #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk_100(clk), .reset(rst), .i2s_bclk(bclk), .i2s_lr(lr), .i2s_sdata(sd),
    .left_sample(left_s), .right_sample(right_s), .sample_valid(valid), .frame_err(ferr)
  );

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [2*DW-1:0] e;
    if (ferr) n_err++;
    if (valid) begin
      n_valid++;
      check("excl", 48'(ferr), 0);
      if (q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        check("left", 48'(left_s), 48'(e[2*DW-1:DW]));
        check("right", 48'(right_s), 48'(e[DW-1:0]));
      end
      if (space_en && last_v != 0) check("spacing", 48'(cyc - last_v), FRAME);
      last_v = cyc;
    end
  end

  task automatic send_chan(input logic l, input logic [DW-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bclk = 1'b0;
      lr = l;
      sd = (i >= 1 && i <= DW) ? w[DW-i] : 1'($urandom);
      repeat (HB) @(negedge clk);
      bclk = 1'b1;
      repeat (HB - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nl, input int nr, input bit push);
    if (push) q.push_back({l, r});
    send_chan(1'b0, l, nl);
    send_chan(1'b1, r, nr);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 48'(q.size()), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_left", 48'(left_s), 0);
    check("rst_right", 48'(right_s), 0);
    check("rst_valid", 48'(valid), 0);
    check("rst_err", 48'(ferr), 0);
    rst = 1'b0;
    send_chan(1'b1, 24'h3C3C3C, 20);
    check("midright_valid", 48'(n_valid), 0);
    check("midright_err", 48'(n_err), 0);
    send_frame(24'h123456, 24'hABCDEF, 32, 32, 1'b1);
    send_frame(24'h000111, 24'h000222, 32, 32, 1'b1);
    send_frame(24'h0BAD00, 24'h00BAD0, 10, 32, 1'b0);
    send_frame(24'h000001, 24'hFFFFFF, 32, 32, 1'b1);
    send_frame(24'h800000, 24'h7FFFFF, 25, 25, 1'b1);
    send_frame(24'h800000, 24'h7FFFFF, 25, 25, 1'b1);
    send_chan(1'b0, 24'h0, 4);
    drain();
    check("p1_valid_cnt", 48'(n_valid), 5);
    check("p1_err_cnt", 48'(n_err), 1);
    check("p1_left", 48'(left_s), 48'h800000);
    check("p1_right", 48'(right_s), 48'h7FFFFF);
    send_chan(1'b0, 24'h555555, 12);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_left", 48'(left_s), 0);
    check("mid_rst_right", 48'(right_s), 0);
    check("mid_rst_valid", 48'(valid), 0);
    send_chan(1'b0, 24'h555555, 12);
    send_chan(1'b1, 24'h666666, 32);
    check("post_rst_valid", 48'(n_valid), 5);
    check("post_rst_err", 48'(n_err), 1);
    last_v = 0;
    space_en = 1'b1;
    send_frame(24'h0A0A0A, 24'h050505, 32, 32, 1'b1);
    for (int i = 0; i < 100; i++) send_frame(24'(2 * i), 24'(2 * i + 1), 32, 32, 1'b1);
    send_chan(1'b0, 24'h0, 4);
    drain();
    check("p2_valid_cnt", 48'(n_valid), 106);
    check("p2_err_cnt", 48'(n_err), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
